// File: rtl/sqrt_pipe_ctrl_if.sv
// Valid/ready handshake bundle for sqrt_pipe_ctrl: operand entry and result exit.
// slave is the controller side, master is the upstream/downstream side.
interface sqrt_pipe_ctrl_if;
   logic in_valid_i;
   logic in_ready_o;
   logic out_valid_o;
   logic out_ready_i;

   modport master (
      output in_valid_i,
      output out_ready_i,
      input  in_ready_o,
      input  out_valid_o
   );

   modport slave (
      input  in_valid_i,
      input  out_ready_i,
      output in_ready_o,
      output out_valid_o
   );
endinterface

// File: rtl/sqrt_pipe_ctrl.sv
// Valid/enable sequencer for a STAGES-deep square-root datapath with bubble collapse.
// Optional flush_i port and flush logic are built only when SQRT_PIPE_CTRL_FLUSH_EN is defined.
module sqrt_pipe_ctrl #(
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SQRT_PIPE_CTRL_FLUSH_EN
   input  logic              flush_i,
`endif
   sqrt_pipe_ctrl_if.slave   hs,
   output logic [STAGES-1:0] en_pipe_o,
   output logic [STAGES-1:0] stage_valid_o,
   output logic [3:0]        occupancy_o,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] en_raw;
   logic [3:0]        occ_q, occ_d;
   logic              tail_full;
   logic              hold;
   logic              accept;
   logic              drain;

`ifdef SQRT_PIPE_CTRL_FLUSH_EN
   assign hold = rst | flush_i;
`else
   assign hold = rst;
`endif

   // A stage may load unless it and every stage after it are full while the output stalls.
   always_comb begin
      en_raw    = '0;
      tail_full = 1'b1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         tail_full = tail_full & v_q[k];
         en_raw[k] = ~tail_full | hs.out_ready_i;
      end
   end

   assign en_pipe_o      = hold ? '0 : en_raw;
   assign hs.in_ready_o  = en_pipe_o[0];
   assign hs.out_valid_o = v_q[STAGES-1];
   assign accept         = hs.in_valid_i & hs.in_ready_o;
   assign drain          = hs.out_valid_o & hs.out_ready_i;

   always_comb begin
      v_d     = v_q;
      occ_d   = occ_q;
      state_d = ST_RUN;

      if (en_pipe_o[0]) begin
         v_d[0] = hs.in_valid_i;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (en_pipe_o[k]) begin
            v_d[k] = v_q[k-1];
         end
      end

      case ({accept, drain})
         2'b10:   occ_d = occ_q + 4'd1;
         2'b01:   occ_d = occ_q - 4'd1;
         default: occ_d = occ_q;
      endcase

`ifdef SQRT_PIPE_CTRL_FLUSH_EN
      // Flush wins over any accept or drain seen in the same cycle.
      if (flush_i) begin
         v_d   = '0;
         occ_d = '0;
      end
`endif

      if (occ_d == 4'd0) begin
         state_d = ST_IDLE;
      end else if (v_d[STAGES-1] && !hs.out_ready_i) begin
         state_d = ST_STALL;
      end else begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= '0;
         occ_q   <= '0;
         state_q <= ST_IDLE;
      end else begin
         v_q     <= v_d;
         occ_q   <= occ_d;
         state_q <= state_d;
      end
   end

   assign stage_valid_o = v_q;
   assign occupancy_o   = occ_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// Bench for sqrt_pipe_ctrl (STAGES = 4): directed scenarios then random traffic,
// checked every cycle against a position-queue model of the operands in flight.
module tb_sqrt_pipe_ctrl;
   localparam int S = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [S-1:0] en_pipe;
   logic [S-1:0] stage_valid;
   logic [3:0]   occ;
   logic [1:0]   st;
`ifdef SQRT_PIPE_CTRL_FLUSH_EN
   logic         flush;
`endif

   sqrt_pipe_ctrl_if hs ();

   sqrt_pipe_ctrl #(.STAGES(S)) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef SQRT_PIPE_CTRL_FLUSH_EN
      .flush_i       (flush),
`endif
      .hs            (hs.slave),
      .en_pipe_o     (en_pipe),
      .stage_valid_o (stage_valid),
      .occupancy_o   (occ),
      .state_o       (st)
   );

   // Model: each entry is the stage index of one operand in flight, oldest first.
   int q[$];
   int exp_st;
   bit known;
   bit iv_c, ordy_c, r_c, fl_c;

   int n_chk, n_pass, cyc;
   int first_acc, first_ov, first_drain, last_drain, n_drain, peak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int cnt_from(input int k);
      int c = 0;
      foreach (q[i]) if (q[i] >= k) c++;
      return c;
   endfunction

   function automatic logic [S-1:0] exp_en();
      logic [S-1:0] e;
      for (int k = 0; k < S; k++)
         e[k] = (r_c || fl_c) ? 1'b0 : (ordy_c || (cnt_from(k) < S - k));
      return e;
   endfunction

   function automatic logic [S-1:0] exp_sv();
      logic [S-1:0] v = '0;
      foreach (q[i]) v[q[i]] = 1'b1;
      return v;
   endfunction

   task automatic clear_stats();
      first_acc = -1; first_ov = -1; first_drain = -1; last_drain = -1;
      n_drain = 0; peak = 0;
   endtask

   task automatic step(input bit iv, input bit ordy, input bit r, input bit fl);
      logic [S-1:0] e;
      logic [S-1:0] sv;
      iv_c = iv; ordy_c = ordy; r_c = r;
`ifdef SQRT_PIPE_CTRL_FLUSH_EN
      fl_c = fl;
      flush = fl;
`else
      fl_c = 1'b0;
      if (fl) fl_c = 1'b0;
`endif
      hs.in_valid_i = iv;
      hs.out_ready_i = ordy;
      rst = r;
      @(negedge clk);
      e = exp_en();
      chk("en_pipe", en_pipe, e);
      chk("in_ready", hs.in_ready_o, e[0]);
      if (known) begin
         sv = exp_sv();
         chk("stage_valid", stage_valid, sv);
         chk("occupancy", occ, q.size());
         chk("state", st, exp_st);
         chk("out_valid", hs.out_valid_o, sv[S-1]);
      end
      if (hs.in_ready_o && iv && first_acc < 0) first_acc = cyc;
      if (hs.out_valid_o && first_ov < 0) first_ov = cyc;
      if (hs.out_valid_o && ordy && !r && !fl_c) begin
         n_drain++;
         if (first_drain < 0) first_drain = cyc;
         last_drain = cyc;
      end
      if (int'(occ) > peak) peak = int'(occ);
   endtask

   task automatic tick();
      logic [S-1:0] e;
      int nq[$];
      int lim;
      e = exp_en();
      @(posedge clk);
      if (r_c || fl_c) begin
         q.delete();
      end else begin
         lim = S;
         foreach (q[i]) begin
            int np;
            if (i == 0 && q[i] == S - 1 && ordy_c) continue;
            np = (q[i] + 1 < lim) ? q[i] + 1 : lim - 1;
            nq.push_back(np);
            lim = np;
         end
         q = nq;
         if (iv_c && e[0]) q.push_back(0);
      end
      if (r_c) known = 1'b1;
      if (q.size() == 0) exp_st = 0;
      else if (q[0] == S - 1 && !ordy_c) exp_st = 2;
      else exp_st = 1;
      cyc++;
      #1;
   endtask

   task automatic cycle(input bit iv, input bit ordy, input bit r, input bit fl);
      step(iv, ordy, r, fl);
      tick();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; known = 1'b0; exp_st = 0;
      clear_stats();
      hs.in_valid_i = 1'b0; hs.out_ready_i = 1'b0; rst = 1'b1;
`ifdef SQRT_PIPE_CTRL_FLUSH_EN
      flush = 1'b0;
`endif
      @(posedge clk); #1;

      // reset and first cycle after it
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("post_rst_in_ready", hs.in_ready_o, 1);
      chk("post_rst_occ", occ, 0);
      chk("post_rst_state", st, 0);
      chk("post_rst_out_valid", hs.out_valid_o, 0);
      tick();

      // streaming
      clear_stats();
      repeat (10) cycle(1, 1, 0, 0);
      repeat (8) cycle(0, 1, 0, 0);
      chk("stream_latency", first_ov - first_acc, S);
      chk("stream_results", n_drain, 10);
      chk("stream_consecutive", last_drain - first_drain, 9);
      chk("stream_peak", peak, 4);

      // fill then stall, full with simultaneous accept/drain, then drain
      cycle(0, 0, 1, 0);
      repeat (4) cycle(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("stall_occ", occ, 4);
      chk("stall_state", st, 2);
      chk("stall_in_ready", hs.in_ready_o, 0);
      chk("stall_en", en_pipe, 4'b0000);
      tick();
      step(1, 1, 0, 0);
      chk("full_sim_en", en_pipe, 4'b1111);
      tick();
      chk("full_sim_occ", occ, 4);
      clear_stats();
      repeat (4) cycle(0, 1, 0, 0);
      chk("drain_count", n_drain, 4);
      chk("drain_consecutive", last_drain - first_drain, 3);
      chk("drain_empty_state", st, 0);

      // bubble collapse
      cycle(0, 0, 1, 0);
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      repeat (3) cycle(0, 0, 0, 0);
      chk("bubble_compact", stage_valid, 4'b1100);
      step(1, 0, 0, 0);
      chk("bubble_ready_2", hs.in_ready_o, 1);
      tick();
      step(1, 0, 0, 0);
      chk("bubble_ready_3", hs.in_ready_o, 1);
      tick();
      step(1, 0, 0, 0);
      chk("bubble_ready_full", hs.in_ready_o, 0);
      tick();

      // reset mid-run
      cycle(0, 0, 1, 0);
      repeat (3) cycle(1, 0, 0, 0);
      chk("midrst_occ_before", occ, 3);
      cycle(0, 0, 1, 0);
      chk("midrst_stage_valid", stage_valid, 4'b0000);
      chk("midrst_state", st, 0);
      chk("midrst_out_valid", hs.out_valid_o, 0);
      repeat (5) cycle(0, 1, 0, 0);

`ifdef SQRT_PIPE_CTRL_FLUSH_EN
      // flush with a pending operand
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("flush_occ_before", occ, 2);
      step(1, 1, 0, 1);
      chk("flush_in_ready", hs.in_ready_o, 0);
      chk("flush_en", en_pipe, 4'b0000);
      tick();
      chk("flush_occ_after", occ, 0);
      chk("flush_state", st, 0);
`endif

      // random traffic with occasional reset/flush
      for (int i = 0; i < 600; i++) begin
         bit iv, ordy, r, fl;
         iv   = ($urandom_range(0, 3) != 0);
         ordy = (i < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
         r    = ($urandom_range(0, 63) == 0);
         fl   = ($urandom_range(0, 47) == 0);
         cycle(iv, ordy, r, fl);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
